// File: rtl/datapath_pkg.sv
// Shared types and field layout for the multi-cycle datapath controller.
package datapath_pkg;

   localparam int unsigned INSTR_W = 24;
   localparam int unsigned REG_AW  = 3;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned OP_W    = 4;

   localparam int unsigned OP_LSB   = 20;
   localparam int unsigned CTRL_LSB = 17;
   localparam int unsigned WA3_LSB  = 14;
   localparam int unsigned RA1_LSB  = 11;
   localparam int unsigned RA2_LSB  = 8;
   localparam int unsigned IMM_LSB  = 0;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 4'd0,
      OP_ALU_R = 4'd1,
      OP_ALU_I = 4'd2,
      OP_LDI   = 4'd3,
      OP_BZ    = 4'd4,
      OP_BNZ   = 4'd5,
      OP_JMP   = 4'd6,
      OP_HALT  = 4'd7
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5,
      ST_ERROR     = 3'd6
   } state_e;

   typedef struct packed {
      opcode_e             op;
      logic                illegal;
      logic [REG_AW-1:0]   ctrl;
      logic [REG_AW-1:0]   wa3;
      logic [REG_AW-1:0]   ra1;
      logic [REG_AW-1:0]   ra2;
      logic [DATA_W-1:0]   imm;
   } decoded_t;

endpackage

// File: rtl/datapath_controller_if.sv
// Instruction-fetch port and datapath control/status bundle.
interface datapath_controller_if #(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 24
);
   logic                 imem_req;
   logic [PC_W-1:0]      imem_addr;
   logic                 imem_ack;
   logic [INSTR_W-1:0]   imem_data;

   logic [datapath_pkg::DATA_W-1:0] ULAResult;
   logic                            Z;
   logic [datapath_pkg::DATA_W-1:0] wd3;
   logic [datapath_pkg::DATA_W-1:0] constante;
   logic [datapath_pkg::REG_AW-1:0] wa3;
   logic [datapath_pkg::REG_AW-1:0] ra1;
   logic [datapath_pkg::REG_AW-1:0] ra2;
   logic [datapath_pkg::REG_AW-1:0] ULAControl;
   logic                            we3;
   logic                            select_src;

   modport master (
      output imem_req, imem_addr, wd3, constante, wa3, ra1, ra2, ULAControl, we3, select_src,
      input  imem_ack, imem_data, ULAResult, Z
   );

   modport slave (
      input  imem_req, imem_addr, wd3, constante, wa3, ra1, ra2, ULAControl, we3, select_src,
      output imem_ack, imem_data, ULAResult, Z
   );
endinterface

// File: rtl/instr_decode.sv
// Splits a raw instruction word into opcode, register fields and immediate.
module instr_decode #(
   parameter int unsigned INSTR_W = 24
) (
   input  logic [INSTR_W-1:0]      instr,
   output datapath_pkg::decoded_t  dec
);
   import datapath_pkg::*;

   logic [OP_W-1:0] raw_op;

   // Opcodes 8-15 share the top bit, so that bit alone flags them illegal.
   always_comb begin
      raw_op      = instr[OP_LSB +: OP_W];
      dec         = '0;
      dec.illegal = raw_op[OP_W-1];
      dec.op      = dec.illegal ? OP_NOP : opcode_e'(raw_op);
      dec.ctrl    = instr[CTRL_LSB +: REG_AW];
      dec.wa3     = instr[WA3_LSB  +: REG_AW];
      dec.ra1     = instr[RA1_LSB  +: REG_AW];
      dec.ra2     = instr[RA2_LSB  +: REG_AW];
      dec.imm     = instr[IMM_LSB  +: DATA_W];
   end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving the 8-bit datapath.
module datapath_controller #(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   datapath_controller_if.master  bus,
   output logic                   busy,
   output logic                   halted,
   output logic                   error
);
   import datapath_pkg::*;

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   decoded_t            dec_in, dec_q, dec_d;
   logic [DATA_W-1:0]   wd3_q, wd3_d;
   logic                sel_q;
   logic                imem_req_q;
   logic                we3_q;
   logic                busy_q, halted_q, error_q;
   logic                fetch_hs;

   instr_decode #(.INSTR_W(INSTR_W)) u_decode (
      .instr (bus.imem_data),
      .dec   (dec_in)
   );

   assign fetch_hs = (state_q == ST_FETCH) && bus.imem_ack;

   // Next-state, next-pc and write-back data selection.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      dec_d   = dec_q;
      wd3_d   = wd3_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.imem_ack) begin
               dec_d   = dec_in;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (dec_q.illegal) begin
               state_d = ST_ERROR;
            end else begin
               case (dec_q.op)
                  OP_NOP: begin
                     pc_d    = pc_q + PC_W'(1);
                     state_d = ST_FETCH;
                  end
                  OP_JMP: begin
                     pc_d    = PC_W'(dec_q.imm);
                     state_d = ST_FETCH;
                  end
                  OP_LDI: begin
                     wd3_d   = dec_q.imm;
                     state_d = ST_WRITEBACK;
                  end
                  OP_HALT: state_d = ST_HALT;
                  default: state_d = ST_EXECUTE;
               endcase
            end
         end
         ST_EXECUTE: begin
            case (dec_q.op)
               OP_BZ: begin
                  pc_d    = bus.Z ? PC_W'(dec_q.imm) : pc_q + PC_W'(1);
                  state_d = ST_FETCH;
               end
               OP_BNZ: begin
                  pc_d    = !bus.Z ? PC_W'(dec_q.imm) : pc_q + PC_W'(1);
                  state_d = ST_FETCH;
               end
               default: begin
                  wd3_d   = bus.ULAResult;
                  state_d = ST_WRITEBACK;
               end
            endcase
         end
         ST_WRITEBACK: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            if (start) begin
               pc_d    = '0;
               state_d = ST_FETCH;
            end
         end
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State, pc, latched instruction and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         dec_q      <= '0;
         wd3_q      <= '0;
         sel_q      <= 1'b0;
         imem_req_q <= 1'b0;
         we3_q      <= 1'b0;
         busy_q     <= 1'b0;
         halted_q   <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         dec_q      <= dec_d;
         wd3_q      <= wd3_d;
         imem_req_q <= (state_d == ST_FETCH);
         we3_q      <= (state_d == ST_WRITEBACK);
         busy_q     <= !(state_d inside {ST_IDLE, ST_HALT, ST_ERROR});
         halted_q   <= (state_d == ST_HALT);
         error_q    <= (state_d == ST_ERROR);
         if (fetch_hs) sel_q <= (dec_in.op == OP_ALU_I) && !dec_in.illegal;
      end
   end

   // Controls come straight from the latched instruction and hold until the next fetch lands.
   assign bus.imem_req   = imem_req_q;
   assign bus.imem_addr  = pc_q;
   assign bus.ra1        = dec_q.ra1;
   assign bus.ra2        = dec_q.ra2;
   assign bus.ULAControl = dec_q.ctrl;
   assign bus.constante  = dec_q.imm;
   assign bus.select_src = sel_q;
   assign bus.wa3        = dec_q.wa3;
   assign bus.wd3        = wd3_q;
   assign bus.we3        = we3_q;
   assign busy           = busy_q;
   assign halted         = halted_q;
   assign error          = error_q;

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench: controller + register-file/ALU model + ROM with per-address ack delay.
module tb_datapath_controller;

   typedef struct {
      logic [7:0] addr;
      int         gap;
   } fexp_t;

   typedef struct {
      logic [2:0] wa3;
      logic [7:0] wd3;
      logic       sel;
      logic [7:0] cst;
   } wexp_t;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic busy, halted, error;

   logic [23:0] rom [256];
   int          dly [256];
   logic [7:0]  rf  [8];
   logic [7:0]  srca, srcb, res;

   fexp_t fq[$];
   wexp_t wq[$];
   int    n_vec  = 0;
   int    n_miss = 0;

   datapath_controller_if #(.PC_W(8), .INSTR_W(24)) bus ();

   datapath_controller #(.PC_W(8), .INSTR_W(24)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bus    (bus.master),
      .busy   (busy),
      .halted (halted),
      .error  (error)
   );

   always #5 clk = ~clk;

   // Datapath model: ctrl 0 add, 1 sub, 2 and, 3 or, 4 xor, else pass A.
   always_comb begin
      srca = rf[bus.ra1];
      srcb = bus.select_src ? bus.constante : rf[bus.ra2];
      case (bus.ULAControl)
         3'd0:    res = srca + srcb;
         3'd1:    res = srca - srcb;
         3'd2:    res = srca & srcb;
         3'd3:    res = srca | srcb;
         3'd4:    res = srca ^ srcb;
         default: res = srca;
      endcase
      bus.ULAResult = res;
      bus.Z         = (res == 8'd0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 8; i++) rf[i] <= 8'd0;
      end else if (bus.we3) begin
         rf[bus.wa3] <= bus.wd3;
      end
   end

   // ROM: acknowledges after dly[addr] wait cycles of a held request.
   initial begin
      int cnt;
      cnt = 0;
      bus.imem_ack  = 1'b0;
      bus.imem_data = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && bus.imem_req) begin
            if (cnt == dly[bus.imem_addr]) begin
               bus.imem_ack  = 1'b1;
               bus.imem_data = rom[bus.imem_addr];
               cnt = 0;
            end else begin
               bus.imem_ack = 1'b0;
               cnt++;
            end
         end else begin
            bus.imem_ack = 1'b0;
            cnt = 0;
         end
      end
   end

   function automatic logic [23:0] ins(input int op, input int ctrl, input int wa,
                                       input int r1, input int r2, input int imm);
      return {4'(op), 3'(ctrl), 3'(wa), 3'(r1), 3'(r2), 8'(imm)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_fetch(input logic [7:0] a, input int g);
      fexp_t e;
      e.addr = a;
      e.gap  = g;
      fq.push_back(e);
   endtask

   task automatic exp_wr(input logic [2:0] wa, input logic [7:0] wd, input logic sel,
                         input logic [7:0] cst);
      wexp_t e;
      e.wa3 = wa;
      e.wd3 = wd;
      e.sel = sel;
      e.cst = cst;
      wq.push_back(e);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // which: 0 halted, 1 error, 2 we3
   task automatic wait_for(input int which, input int budget, input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(posedge clk);
         #1;
         case (which)
            0:       hit = halted;
            1:       hit = error;
            default: hit = bus.we3;
         endcase
      end
      n_vec++;
      if (!hit) begin
         n_miss++;
         $display("FAIL %s: no event within %0d cycles", name, budget);
      end
   endtask

   // Monitor: pops fetch and write expectations whenever the DUT presents them.
   task automatic monitor();
      int         cyc, last_hs;
      logic       req_p, hs_p;
      logic [7:0] addr_p;
      fexp_t      fe;
      wexp_t      we;
      cyc = 0; last_hs = 0; req_p = 1'b0; hs_p = 1'b0; addr_p = '0;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (rst !== 1'b1) begin
            req_p = 1'b0;
            hs_p  = 1'b0;
            continue;
         end
         if (bus.imem_req && req_p && !hs_p)
            chk("addr_stable", 32'(bus.imem_addr), 32'(addr_p));
         if (bus.imem_req && bus.imem_ack) begin
            if (fq.size() == 0) begin
               chk("unexpected_fetch", 32'(bus.imem_addr), 32'hFFFF_FFFF);
            end else begin
               fe = fq.pop_front();
               chk("fetch_addr", 32'(bus.imem_addr), 32'(fe.addr));
               if (fe.gap >= 0) chk("instr_cycles", 32'(cyc - last_hs), 32'(fe.gap));
            end
            last_hs = cyc;
         end
         if (bus.we3) begin
            if (wq.size() == 0) begin
               chk("unexpected_we3", 32'(bus.wa3), 32'hFFFF_FFFF);
            end else begin
               we = wq.pop_front();
               chk("wb_wa3", 32'(bus.wa3), 32'(we.wa3));
               chk("wb_wd3", 32'(bus.wd3), 32'(we.wd3));
               chk("wb_select_src", 32'(bus.select_src), 32'(we.sel));
               chk("wb_constante", 32'(bus.constante), 32'(we.cst));
            end
         end
         req_p  = bus.imem_req;
         addr_p = bus.imem_addr;
         hs_p   = bus.imem_req && bus.imem_ack;
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_we3"},      32'(bus.we3), 0);
      chk({tag, "_imem_req"}, 32'(bus.imem_req), 0);
      chk({tag, "_imem_addr"},32'(bus.imem_addr), 0);
      chk({tag, "_wd3"},      32'(bus.wd3), 0);
      chk({tag, "_wa3"},      32'(bus.wa3), 0);
      chk({tag, "_busy"},     32'(busy), 0);
      chk({tag, "_halted"},   32'(halted), 0);
      chk({tag, "_error"},    32'(error), 0);
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         rom[i] = 24'h0;
         dly[i] = 0;
      end
      fork
         monitor();
      join_none

      repeat (3) @(negedge clk);
      chk_quiet("reset");
      @(negedge clk);
      rst = 1'b1;

      // Run 1: LDI/ALU_R/ALU_I write-back, BZ taken, BNZ not taken, HALT.
      rom[8'h00] = ins(3, 0, 1, 0, 0, 5);
      rom[8'h01] = ins(3, 0, 2, 0, 0, 3);
      rom[8'h02] = ins(1, 0, 3, 1, 2, 0);
      rom[8'h03] = ins(2, 1, 4, 1, 0, 5);
      rom[8'h04] = ins(4, 1, 0, 1, 1, 8'h20);
      rom[8'h20] = ins(5, 1, 0, 1, 1, 8'h30);
      rom[8'h21] = ins(7, 0, 0, 0, 0, 0);
      exp_fetch(8'h00, -1);
      exp_fetch(8'h01, 3);
      exp_fetch(8'h02, 3);
      exp_fetch(8'h03, 4);
      exp_fetch(8'h04, 4);
      exp_fetch(8'h20, 3);
      exp_fetch(8'h21, 3);
      exp_wr(3'd1, 8'd5, 1'b0, 8'd5);
      exp_wr(3'd2, 8'd3, 1'b0, 8'd3);
      exp_wr(3'd3, 8'd8, 1'b0, 8'd0);
      exp_wr(3'd4, 8'd0, 1'b1, 8'd5);
      pulse_start();
      wait_for(0, 200, "halt_run1");
      @(negedge clk);
      chk("run1_halted", 32'(halted), 1);
      chk("run1_busy", 32'(busy), 0);
      chk("run1_pc", 32'(bus.imem_addr), 32'h21);

      // Run 2: restart from 0, delayed ack, pc wrap, BNZ both ways, start while busy.
      rom[8'h00] = ins(5, 2, 0, 7, 7, 8'h40);
      rom[8'h01] = ins(3, 0, 7, 0, 0, 1);
      rom[8'h02] = ins(6, 0, 0, 0, 0, 8'hFF);
      rom[8'hFF] = ins(0, 0, 0, 0, 0, 0);
      rom[8'h40] = ins(7, 0, 0, 0, 0, 0);
      dly[8'h01] = 3;
      exp_fetch(8'h00, -1);
      exp_fetch(8'h01, 6);
      exp_fetch(8'h02, 3);
      exp_fetch(8'hFF, 2);
      exp_fetch(8'h00, 2);
      exp_fetch(8'h40, 3);
      exp_wr(3'd7, 8'd1, 1'b0, 8'd1);
      pulse_start();
      repeat (3) @(negedge clk);
      pulse_start();
      wait_for(0, 200, "halt_run2");
      @(negedge clk);
      chk("run2_halted", 32'(halted), 1);
      chk("run2_pc", 32'(bus.imem_addr), 32'h40);

      // Illegal opcode: sticky ERROR, start ignored.
      rom[8'h00] = ins(10, 0, 0, 0, 0, 0);
      exp_fetch(8'h00, -1);
      pulse_start();
      wait_for(1, 50, "error");
      @(negedge clk);
      chk("err_error", 32'(error), 1);
      chk("err_busy", 32'(busy), 0);
      chk("err_halted", 32'(halted), 0);
      chk("err_pc", 32'(bus.imem_addr), 0);
      pulse_start();
      repeat (6) @(negedge clk);
      chk("err_sticky", 32'(error), 1);
      chk("err_no_req", 32'(bus.imem_req), 0);

      // Reset clears ERROR; then reset in the middle of a write-back.
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_clears_error", 32'(error), 0);
      rst = 1'b1;
      rom[8'h00] = ins(3, 0, 1, 0, 0, 8'h5A);
      exp_fetch(8'h00, -1);
      pulse_start();
      wait_for(2, 50, "reach_writeback");
      #2;
      rst = 1'b0;
      #1;
      chk("wb_reset_we3", 32'(bus.we3), 0);
      chk_quiet("wb_reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_quiet("post_reset");

      chk("fetch_queue_empty", 32'(fq.size()), 0);
      chk("write_queue_empty", 32'(wq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/datapath_controller.md
# datapath_controller

Multi-cycle control unit sitting directly upstream of the 8-bit datapath (register file + source mux + ULA). Fetches 24-bit instructions over a simple request/acknowledge port, decodes them, drives every datapath control input (`wa3`, `ra1`, `ra2`, `ULAControl`, `select_src`, `constante`, `we3`, `wd3`), samples `ULAResult`/`Z` back, and sequences write-back and conditional branches. One instruction is in flight at a time; there is no pipelining.

## Interface
Parameters:
- `PC_W`, default 8: program counter / instruction address width.
- `INSTR_W`, default 24: instruction width; the field map below is fixed for 24.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; leaves IDLE or HALT.
- `imem_req`  out  1  fetch request, held until acknowledged.
- `imem_addr`  out  PC_W  fetch address (= pc).
- `imem_ack`  in  1  fetch data valid this cycle.
- `imem_data`  in  INSTR_W  instruction word.
- `ULAResult`  in  8  datapath ALU result (combinational from current controls).
- `Z`  in  1  datapath zero flag.
- `wd3`, `constante`  out  8  write data / immediate to datapath.
- `wa3`, `ra1`, `ra2`, `ULAControl`  out  3  register addresses / ALU op.
- `we3`, `select_src`  out  1  register write enable / immediate select (1 = `constante`).
- `busy`  out  1  high in any state except IDLE, HALT, ERROR.
- `halted`, `error`  out  1  high in HALT / ERROR.

## Operation
- Field map: op[23:20], ctrl[19:17], wa3[16:14], ra1[13:11], ra2[10:8], imm[7:0].
- Opcodes:
  - 0 NOP.
  - 1 ALU_R: `select_src`=0.
  - 2 ALU_I: `select_src`=1, `constante`=imm.
  - 3 LDI: reg[wa3] ← imm, ULA unused.
  - 4 BZ / 5 BNZ: evaluate ULA(ra1, ra2, ctrl); pc ← imm if Z==1 (BZ) or Z==0 (BNZ), else pc+1.
  - 6 JMP: pc ← imm.
  - 7 HALT.
  - 8–15 illegal → ERROR.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT, ERROR.
  - IDLE: `start` → FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=pc; on `imem_ack`, latch instruction → DECODE.
  - DECODE: drive `ra1`, `ra2`, `ULAControl`, `select_src`, `constante` from fields. Then:
    - NOP: pc+1 → FETCH.
    - JMP: pc ← imm → FETCH.
    - LDI: latch result=imm → WRITEBACK.
    - HALT → HALT.
    - illegal → ERROR.
    - ALU/branch → EXECUTE.
  - EXECUTE: controls held; sample `ULAResult` into result register and `Z` into flag register.
    - ALU_R/ALU_I → WRITEBACK.
    - Branch: update pc → FETCH.
  - WRITEBACK: `we3`=1, `wa3`=field, `wd3`=latched result for exactly one cycle; pc+1 → FETCH.
  - HALT: `start` → pc ← 0, FETCH. `start` is ignored while busy.
  - ERROR: sticky until reset; pc frozen at the offending address.
- pc arithmetic is modulo 2^PC_W: 255+1 wraps to 0. Branch and JMP targets are imm zero-extended.
- The datapath register file reads combinationally and writes on the clock edge; the controller never asserts `we3` outside WRITEBACK.

## Timing
- Reset (async assert, sync release): state IDLE, pc 0. All outputs 0, including `we3`, `imem_req`, `busy`, `halted`, `error`.
- All outputs are registered or decoded from registered state only; no `imem_data` → output combinational path.
- Minimum cycles per instruction (with `imem_ack` in the first FETCH cycle):
  - NOP/JMP: 2.
  - LDI: 3.
  - BZ/BNZ: 3.
  - ALU_R/ALU_I: 4.
  - Each cycle of `imem_ack` delay adds one.
- `imem_addr` is stable while `imem_req`=1; `imem_req` deasserts the cycle after ack.
- `imem_ack` outside FETCH is ignored.
- `start` while already busy: no effect.
- Reset mid-WRITEBACK: `we3` drops asynchronously; no write is guaranteed.

## Structure
- `datapath_pkg`: opcode enum, state enum, field bit positions, `INSTR_W`, register-address width (3), data width (8).
- One combinational sub-module, `instr_decode`: instruction word → op class, fields, illegal flag. The FSM, pc and result/flag registers stay in `datapath_controller`.
- The top-level test harness connects `datapath_controller` to the existing datapath plus a ROM model.

## Test plan
- LDI r1,5; LDI r2,3; ALU_R r3=r1+r2 → WRITEBACK drives `we3`=1, `wa3`=3, `wd3`=8; ALU instruction takes 4 cycles.
- ALU_I r4=r1-imm 5 → `select_src`=1, `constante`=5, Z sampled 1, r4 written 0.
- BZ with Z=1, imm=0x20 → next `imem_addr`=0x20. BNZ on the same operands → `imem_addr`=pc+1.
- pc=0xFF executing NOP → next fetch address 0x00. `imem_ack` delayed 3 cycles → `imem_req` held, `imem_addr` stable, instruction latency +3.
- op=0xA → `error`=1, `busy`=0, `start` ignored. HALT → `halted`=1; `start` → fetch from 0x00.
- Reset asserted during WRITEBACK → `we3`=0 immediately; after release: IDLE, pc 0, all outputs 0.
